// File: rtl/req_encoder.sv
// Registered request encoder: sticky pending capture, one-at-a-time index presentation on valid/ready.
// Optional REQ_ENCODER_RR_EN selects round-robin priority; default is fixed lowest-index-first.
module req_encoder #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  output logic [IDX_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pending
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] clr;
  logic [IDX_W-1:0] sel_idx;
  logic             handshake;

`ifdef REQ_ENCODER_RR_EN
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             found;

  // Search starts at the pointer and wraps; power-of-two WIDTH makes the index add wrap naturally.
  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      if (!found && pend_q[rr_q + IDX_W'(k)]) begin
        sel_idx = rr_q + IDX_W'(k);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (handshake) rr_d = out_q + IDX_W'(1);
  end
`else
  // Fixed priority: scanning downward leaves the lowest set index selected.
  always_comb begin
    sel_idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = IDX_W'(i);
    end
  end
`endif

  // Next-state, presented index and pending update.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    valid_d   = valid_q;
    clr       = '0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          out_d   = sel_idx;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          handshake   = 1'b1;
          clr[out_q]  = 1'b1;
          valid_d     = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    // Set is OR-ed after the clear so a re-request in the handshake cycle survives.
    pend_d = (pend_q & ~clr) | (in & {WIDTH{enable}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
`ifdef REQ_ENCODER_RR_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
`ifdef REQ_ENCODER_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_req_encoder.sv
// Directed self-checking bench for req_encoder (default fixed-priority build, WIDTH=4).
module tb_req_encoder;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned IDX_W = 2;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] in;
  logic [IDX_W-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] pending;

  int total = 0;
  int bad   = 0;

  req_encoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Checks valid, and out only when a value is expected to be presented.
  task automatic chk_state(input string tag, input logic v, input logic [IDX_W-1:0] o,
                           input logic [WIDTH-1:0] p);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, ".out"}, 32'(out), 32'(o));
    chk({tag, ".pend"}, 32'(pending), 32'(p));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in = '0; out_ready = 1'b0;

    // Reset then idle
    tick();
    chk("rst0.out", 32'(out), 32'd0);
    chk_state("rst0", 1'b0, 2'd0, 4'b0000);
    tick();
    chk("rst1.out", 32'(out), 32'd0);
    chk_state("rst1", 1'b0, 2'd0, 4'b0000);
    reset = 1'b0;

    // Single request, index 2
    enable = 1'b1; out_ready = 1'b1; in = 4'b0100;
    tick(); chk_state("single.cap", 1'b0, 2'd0, 4'b0100);
    in = '0;
    tick(); chk_state("single.pres", 1'b1, 2'd2, 4'b0100);
    tick(); chk_state("single.done", 1'b0, 2'd0, 4'b0000);
    tick(); chk_state("single.idle", 1'b0, 2'd0, 4'b0000);

    // Multi-hot, fixed priority 0,1,3 with bubbles
    in = 4'b1011;
    tick(); chk_state("multi.cap", 1'b0, 2'd0, 4'b1011);
    in = '0;
    tick(); chk_state("multi.i0", 1'b1, 2'd0, 4'b1011);
    tick(); chk_state("multi.b0", 1'b0, 2'd0, 4'b1010);
    tick(); chk_state("multi.i1", 1'b1, 2'd1, 4'b1010);
    tick(); chk_state("multi.b1", 1'b0, 2'd0, 4'b1000);
    tick(); chk_state("multi.i3", 1'b1, 2'd3, 4'b1000);
    tick(); chk_state("multi.b3", 1'b0, 2'd0, 4'b0000);

    // Backpressure: out held, later request only accumulates
    out_ready = 1'b0; in = 4'b0010;
    tick(); chk_state("bp.cap", 1'b0, 2'd0, 4'b0010);
    in = '0;
    tick(); chk_state("bp.pres", 1'b1, 2'd1, 4'b0010);
    in = 4'b0001;
    tick(); chk_state("bp.acc", 1'b1, 2'd1, 4'b0011);
    in = '0;
    tick(); chk_state("bp.hold1", 1'b1, 2'd1, 4'b0011);
    tick(); chk_state("bp.hold2", 1'b1, 2'd1, 4'b0011);
    tick(); chk_state("bp.hold3", 1'b1, 2'd1, 4'b0011);
    out_ready = 1'b1;
    tick(); chk_state("bp.ack", 1'b0, 2'd0, 4'b0001);
    tick(); chk_state("bp.next", 1'b1, 2'd0, 4'b0001);
    tick(); chk_state("bp.done", 1'b0, 2'd0, 4'b0000);

    // Set wins over clear in the handshake cycle
    out_ready = 1'b0; in = 4'b0010;
    tick(); chk_state("swc.cap", 1'b0, 2'd0, 4'b0010);
    in = '0;
    tick(); chk_state("swc.pres", 1'b1, 2'd1, 4'b0010);
    in = 4'b0010; out_ready = 1'b1;
    tick(); chk_state("swc.ack", 1'b0, 2'd0, 4'b0010);
    in = '0;
    tick(); chk_state("swc.again", 1'b1, 2'd1, 4'b0010);
    tick(); chk_state("swc.done", 1'b0, 2'd0, 4'b0000);

    // Enable low ignores requests
    enable = 1'b0; in = 4'b1111;
    tick(); chk_state("en.off0", 1'b0, 2'd0, 4'b0000);
    tick(); chk_state("en.off1", 1'b0, 2'd0, 4'b0000);
    enable = 1'b1; in = '0;

    // Reset while presenting drops everything
    out_ready = 1'b0; in = 4'b1100;
    tick(); chk_state("rmid.cap", 1'b0, 2'd0, 4'b1100);
    in = '0;
    tick(); chk_state("rmid.pres", 1'b1, 2'd2, 4'b1100);
    reset = 1'b1;
    tick();
    chk("rmid.rst.out", 32'(out), 32'd0);
    chk_state("rmid.rst", 1'b0, 2'd0, 4'b0000);
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_state("rmid.quiet", 1'b0, 2'd0, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
